// File: rtl/lmsm_sequencer.sv
// LM/SM multi-register transfer sequencer: walks the register mask one
// register per cycle, stalling the front of the pipeline while it runs.
module lmsm_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Is_Load,
    input  logic [7:0]  Imm8,
    input  logic [15:0] Base_Addr,
    input  logic        Abort,
    output logic [2:0]  Reg_Addr,
    output logic [15:0] Mem_Addr,
    output logic        RF_Write_En,
    output logic        Mem_Write_En,
    output logic        Stallbar,
    output logic        Busy,
    output logic        Done,
    output logic [3:0]  Xfer_Count
);

    localparam int unsigned MASK_W = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [MASK_W-1:0]   r_mask;
    logic                r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_count;

    logic [REG_W-1:0]    w_reg;
    logic [MASK_W-1:0]   w_bit;
    logic [MASK_W-1:0]   w_mask_next;
    logic                w_xfer;

    // Lowest-numbered selected register: mask bit 7 is R0, bit 0 is R7
    always_comb begin
        w_reg = '0;
        for (int j = 7; j >= 0; j--) begin
            if (r_mask[7 - j]) begin
                w_reg = REG_W'(j);
            end
        end
    end

    assign w_bit       = MASK_W'(8'h80) >> w_reg;
    assign w_mask_next = r_mask & ~w_bit;
    assign w_xfer      = (r_state == S_XFER);

    // Sequencer state, latched operands and transfer counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_op    <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A flush in the same cycle kills the instruction in decode
                    if (Start && !Abort) begin
                        r_mask  <= Imm8;
                        r_op    <= Is_Load;
                        r_addr  <= Base_Addr;
                        r_count <= '0;
                        r_state <= (Imm8 == '0) ? S_DONE : S_XFER;
                    end
                end
                S_XFER: begin
                    if (Abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_mask  <= w_mask_next;
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_count <= r_count + CNT_W'(1);
                        r_state <= (w_mask_next == '0) ? S_DONE : S_XFER;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from state; strobes and Done squashed by a same-cycle flush
    assign Reg_Addr     = w_xfer ? w_reg  : '0;
    assign Mem_Addr     = w_xfer ? r_addr : '0;
    assign RF_Write_En  = w_xfer &  r_op & ~Abort;
    assign Mem_Write_En = w_xfer & ~r_op & ~Abort;
    assign Done         = (r_state == S_DONE) & ~Abort;
    assign Stallbar     = ~w_xfer;
    assign Busy         = (r_state != S_IDLE);
    assign Xfer_Count   = r_count;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: stimulus pushes expected strobe/Done
// events, a negedge monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_lmsm_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Is_Load;
    logic [7:0]  Imm8;
    logic [15:0] Base_Addr;
    logic        Abort;
    logic [2:0]  Reg_Addr;
    logic [15:0] Mem_Addr;
    logic        RF_Write_En;
    logic        Mem_Write_En;
    logic        Stallbar;
    logic        Busy;
    logic        Done;
    logic [3:0]  Xfer_Count;

    // kind: 0 = RF write, 1 = memory write, 2 = Done
    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  rg;
        logic [15:0] addr;
        logic [3:0]  cnt;
        logic [31:0] cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    lmsm_sequencer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Is_Load      (Is_Load),
        .Imm8         (Imm8),
        .Base_Addr    (Base_Addr),
        .Abort        (Abort),
        .Reg_Addr     (Reg_Addr),
        .Mem_Addr     (Mem_Addr),
        .RF_Write_En  (RF_Write_En),
        .Mem_Write_En (Mem_Write_En),
        .Stallbar     (Stallbar),
        .Busy         (Busy),
        .Done         (Done),
        .Xfer_Count   (Xfer_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " stallbar"}, 32'(Stallbar), 32'd1);
        chk({tag, " busy"},     32'(Busy), 32'd0);
        chk({tag, " done"},     32'(Done), 32'd0);
        chk({tag, " strobes"},  32'({RF_Write_En, Mem_Write_En}), 32'd0);
        chk({tag, " reg_addr"}, 32'(Reg_Addr), 32'd0);
        chk({tag, " mem_addr"}, 32'(Mem_Addr), 32'd0);
        chk({tag, " count"},    32'(Xfer_Count), 32'd0);
    endtask

    // Monitor: every strobe or Done must match the head of the scoreboard
    always @(negedge Clk) begin
        if (Reset && (RF_Write_En || Mem_Write_En || Done)) begin
            ev_t act;
            act.kind = Done ? 2'd2 : (Mem_Write_En ? 2'd1 : 2'd0);
            act.rg   = Reg_Addr;
            act.addr = Mem_Addr;
            act.cnt  = Xfer_Count;
            act.cyc  = 32'(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got kind=%0d reg=%0d addr=%h cnt=%0d cyc=%0d expected none",
                         act.kind, act.rg, act.addr, act.cnt, act.cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (act !== e || (RF_Write_En && Mem_Write_En)) begin
                    n_fail++;
                    $display("FAIL event: got kind=%0d reg=%0d addr=%h cnt=%0d cyc=%0d expected kind=%0d reg=%0d addr=%h cnt=%0d cyc=%0d",
                             act.kind, act.rg, act.addr, act.cnt, act.cyc,
                             e.kind, e.rg, e.addr, e.cnt, e.cyc);
                end
            end
        end
    end

    // One LM/SM operation; abort_at = 1-based XFER cycle carrying Abort (0 = none)
    task automatic run_op(input logic ld, input logic [7:0] imm, input logic [15:0] base,
                          input int abort_at, input logic repulse);
        int   n;
        int   c0;
        int   committed;
        logic aborted;
        ev_t  e;
        n = 0;
        @(posedge Clk); #1;
        c0 = cyc;
        Start = 1'b1; Is_Load = ld; Imm8 = imm; Base_Addr = base;
        for (int j = 0; j < 8; j++) begin
            if (imm[7 - j]) begin
                if (abort_at == 0 || n < abort_at - 1) begin
                    e.kind = ld ? 2'd0 : 2'd1;
                    e.rg   = 3'(j);
                    e.addr = base + 16'(n);
                    e.cnt  = 4'(n);
                    e.cyc  = 32'(c0 + 1 + n);
                    exp_q.push_back(e);
                end
                n++;
            end
        end
        aborted   = (abort_at != 0) && (abort_at <= n);
        committed = aborted ? abort_at - 1 : n;
        if (!aborted) begin
            e.kind = 2'd2; e.rg = 3'd0; e.addr = 16'h0000;
            e.cnt  = 4'(n); e.cyc = 32'(c0 + 1 + n);
            exp_q.push_back(e);
        end
        for (int i = 1; i <= n + 2; i++) begin
            logic exp_busy, exp_stallbar;
            @(posedge Clk); #1;
            Start = (repulse && i == 2);
            if (repulse) begin
                Imm8 = 8'h3C; Base_Addr = 16'h5555; Is_Load = ~ld;
            end
            Abort = (i == abort_at);
            if (aborted && i > abort_at) begin
                exp_busy = 1'b0; exp_stallbar = 1'b1;
            end else if (i <= n) begin
                exp_busy = 1'b1; exp_stallbar = 1'b0;
            end else if (i == n + 1) begin
                exp_busy = 1'b1; exp_stallbar = 1'b1;
            end else begin
                exp_busy = 1'b0; exp_stallbar = 1'b1;
            end
            chk($sformatf("busy imm=%h i=%0d", imm, i), 32'(Busy), 32'(exp_busy));
            chk($sformatf("stallbar imm=%h i=%0d", imm, i), 32'(Stallbar), 32'(exp_stallbar));
        end
        Abort = 1'b0; Start = 1'b0;
        chk($sformatf("final count imm=%h", imm), 32'(Xfer_Count), 32'(committed));
    endtask

    initial begin
        ev_t e;
        Reset = 1'b0; Start = 1'b0; Is_Load = 1'b0; Imm8 = 8'h00;
        Base_Addr = 16'h0000; Abort = 1'b0;
        repeat (2) @(posedge Clk);
        #1 chk_reset_vals("in_reset");
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk_reset_vals("after_release");

        run_op(1'b1, 8'hA5, 16'h0100, 0, 1'b0);   // LM R0,R2,R5,R7
        run_op(1'b0, 8'h00, 16'h1234, 0, 1'b0);   // empty mask
        run_op(1'b0, 8'hFF, 16'hFFFE, 0, 1'b0);   // address wrap
        run_op(1'b1, 8'h0F, 16'h0300, 2, 1'b0);   // abort in 2nd XFER
        run_op(1'b1, 8'h81, 16'h0400, 0, 1'b1);   // Start re-pulsed mid-run

        // Abort with Start in IDLE: instruction is flushed, nothing starts
        @(posedge Clk); #1;
        Start = 1'b1; Abort = 1'b1; Imm8 = 8'h80; Is_Load = 1'b1; Base_Addr = 16'h0777;
        @(posedge Clk); #1;
        Start = 1'b0; Abort = 1'b0;
        chk("abort_start_idle busy", 32'(Busy), 32'd0);
        @(posedge Clk); #1;
        chk("abort_start_idle busy2", 32'(Busy), 32'd0);

        // Reset dropped in the 3rd XFER cycle of an 0xFF SM
        @(posedge Clk); #1;
        Start = 1'b1; Is_Load = 1'b0; Imm8 = 8'hFF; Base_Addr = 16'h0200;
        for (int k = 0; k < 2; k++) begin
            e.kind = 2'd1; e.rg = 3'(k); e.addr = 16'h0200 + 16'(k);
            e.cnt = 4'(k); e.cyc = 32'(cyc + 1 + k);
            exp_q.push_back(e);
        end
        @(posedge Clk); #1; Start = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("mid_xfer strobe before reset", 32'(Mem_Write_En), 32'd1);
        Reset = 1'b0;
        #1 chk_reset_vals("mid_xfer_reset");
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        run_op(1'b1, 8'h40, 16'h0010, 0, 1'b0);   // normal run after reset

        repeat (2) @(posedge Clk);
        #1 chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
